// File: rtl/eth_tx_mac.sv
// Gigabit Ethernet transmit MAC: preamble/SFD, payload, optional pad, CRC-32 FCS, IFG.
// Optional feature macro: ETH_TX_PAD_EN (pad short payloads to 60 bytes).
//
// state    | meaning
// IDLE     | waiting for i_s_valid, line quiet
// PREAMBLE | seven 0x55 bytes
// SFD      | 0xD5, first payload byte may be accepted
// DATA     | payload bytes on the line
// PAD      | 0x00 fill up to minimum payload length
// FCS      | four CRC bytes, LSB first
// IFG      | inter-frame gap, line quiet, still busy
module eth_tx_mac #(
  parameter int IFG_BYTES = 12
) (
  input  logic       i_tx_clk,
  input  logic       i_tx_rst,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  input  logic       i_s_last,
  output logic       o_s_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_underrun
);

`ifdef ETH_TX_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  localparam int          CNT_W    = 16;
  localparam logic [10:0] MIN_LEN  = 11'd60;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [31:0]       crc, crc_nxt;
  logic [31:0]       fcs_sr, fcs_sr_nxt;
  logic [31:0]       fcs_word;
  logic [10:0]       byte_cnt, byte_cnt_nxt;
  logic              last_done, last_done_nxt;
  logic [7:0]        tx_data_nxt;
  logic              ready_nxt, underrun_nxt, done_nxt;
  logic              start_frame, load_fcs;
  logic              accept, starve;

  assign accept = o_s_ready & i_s_valid;
  assign starve = o_s_ready & ~i_s_valid;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    crc_nxt       = crc;
    fcs_sr_nxt    = fcs_sr;
    fcs_word      = 32'h0;
    byte_cnt_nxt  = byte_cnt;
    last_done_nxt = last_done;
    tx_data_nxt   = 8'h00;
    underrun_nxt  = 1'b0;
    done_nxt      = 1'b0;
    start_frame   = 1'b0;
    load_fcs      = 1'b0;

    case (state)
      IDLE: start_frame = i_s_valid;
      PREAMBLE: begin
        if (cnt == '0) begin
          state_nxt   = SFD;
          tx_data_nxt = 8'hD5;
        end else begin
          cnt_nxt     = cnt - CNT_W'(1);
          tx_data_nxt = 8'h55;
        end
      end
      SFD, DATA: begin
        if (accept) begin
          state_nxt     = DATA;
          tx_data_nxt   = i_s_data;
          crc_nxt       = crc_byte(crc, i_s_data);
          byte_cnt_nxt  = sat_inc(byte_cnt);
          last_done_nxt = i_s_last;
        end else if (starve) begin
          // starved mid-frame: send the uncomplemented CRC so the FCS is wrong
          underrun_nxt = 1'b1;
          load_fcs     = 1'b1;
          fcs_word     = crc;
        end else if (last_done) begin
          if (PAD_EN && (byte_cnt < MIN_LEN)) begin
            state_nxt    = PAD;
            crc_nxt      = crc_byte(crc, 8'h00);
            byte_cnt_nxt = sat_inc(byte_cnt);
          end else begin
            load_fcs = 1'b1;
            fcs_word = ~crc;
          end
        end
      end
      PAD: begin
        if (byte_cnt < MIN_LEN) begin
          crc_nxt      = crc_byte(crc, 8'h00);
          byte_cnt_nxt = sat_inc(byte_cnt);
        end else begin
          load_fcs = 1'b1;
          fcs_word = ~crc;
        end
      end
      FCS: begin
        if (cnt == '0) begin
          state_nxt = IFG;
          cnt_nxt   = CNT_W'(IFG_BYTES - 1);
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt     = cnt - CNT_W'(1);
          tx_data_nxt = fcs_sr[7:0];
          fcs_sr_nxt  = {8'h00, fcs_sr[31:8]};
        end
      end
      IFG: begin
        if (cnt == '0) begin
          if (i_s_valid) start_frame = 1'b1;
          else state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start_frame) begin
      state_nxt     = PREAMBLE;
      cnt_nxt       = CNT_W'(6);
      crc_nxt       = CRC_INIT;
      byte_cnt_nxt  = 11'd0;
      last_done_nxt = 1'b0;
      tx_data_nxt   = 8'h55;
    end

    if (load_fcs) begin
      state_nxt   = FCS;
      cnt_nxt     = CNT_W'(3);
      tx_data_nxt = fcs_word[7:0];
      fcs_sr_nxt  = {8'h00, fcs_word[31:8]};
    end

    ready_nxt = (state_nxt == SFD) || ((state_nxt == DATA) && !last_done_nxt);
  end

  always_ff @(posedge i_tx_clk or posedge i_tx_rst) begin
    if (i_tx_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      crc          <= CRC_INIT;
      fcs_sr       <= 32'h0;
      byte_cnt     <= 11'd0;
      last_done    <= 1'b0;
      o_tx_data    <= 8'h00;
      o_tx_en      <= 1'b0;
      o_s_ready    <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      crc          <= crc_nxt;
      fcs_sr       <= fcs_sr_nxt;
      byte_cnt     <= byte_cnt_nxt;
      last_done    <= last_done_nxt;
      o_tx_data    <= tx_data_nxt;
      o_tx_en      <= (state_nxt != IDLE) && (state_nxt != IFG);
      o_s_ready    <= ready_nxt;
      o_busy       <= (state_nxt != IDLE);
      o_frame_done <= done_nxt;
      o_underrun   <= underrun_nxt;
    end
  end

endmodule
